// File: rtl/dma_channel.sv
// Single-channel DMA engine moving words between a device port and a memory port.
// Reads fetch one word per handshake; writes stage device words in a 4-entry FIFO.
module dma_channel #(
  parameter int DATA = 8,
  parameter int ADD  = 7,
  parameter int WORD = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rqst,
  input  logic [WORD:0]   num_words,
  input  logic [ADD-1:0]  start_address,
  input  logic            rd_wr,
  input  logic            dev_ack,
  input  logic [DATA-1:0] dev_out,
  output logic            dma_ack,
  output logic [DATA-1:0] dev_in,
  output logic            dma_end_flag,
  output logic            mem_req,
  input  logic            mem_gnt,
  output logic            mem_we,
  output logic [ADD-1:0]  mem_addr,
  output logic [DATA-1:0] mem_wdata,
  input  logic [DATA-1:0] mem_rdata,
  output logic            busy,
  output logic            error
);

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] GRANT    = 4'd1;
  localparam logic [3:0] RD_FETCH = 4'd2;
  localparam logic [3:0] RD_WAIT  = 4'd3;
  localparam logic [3:0] RD_OFFER = 4'd4;
  localparam logic [3:0] WR_XFER  = 4'd5;
  localparam logic [3:0] WR_DRAIN = 4'd6;
  localparam logic [3:0] DONE     = 4'd7;
  localparam logic [3:0] ERR      = 4'd8;

  localparam logic [WORD:0] CNT_ONE  = 1;
  localparam logic [ADD-1:0] ADDR_ONE = 1;

  logic [3:0]      state;
  logic [3:0]      state_next;
  logic [WORD:0]   len_q;
  logic            dir_q;
  logic [WORD:0]   cnt;
  logic [WORD:0]   cnt_inc;
  logic [ADD-1:0]  addr;
  logic [3:0]      to_cnt;

  logic [DATA-1:0] fifo_mem [4];
  logic [1:0]      wr_ptr;
  logic [1:0]      rd_ptr;
  logic [2:0]      fifo_cnt;
  logic            fifo_full;
  logic            fifo_empty;

  logic            wr_open;
  logic            offer;
  logic            push;
  logic            pop;
  logic            drain_phase;
  logic            timeout;

  assign fifo_full   = (fifo_cnt == 3'd4);
  assign fifo_empty  = (fifo_cnt == 3'd0);
  assign cnt_inc     = cnt + CNT_ONE;
  assign drain_phase = (state == WR_XFER) || (state == WR_DRAIN);

  // Device handshake: dma_ack is the channel's valid/ready, dev_ack the device's.
  // A word moves only in a cycle where both are high; GRANT's dma_ack is a start
  // notification and never transfers data.
  assign wr_open = (state == WR_XFER) && !fifo_full && (cnt < len_q);
  assign offer   = (state == RD_OFFER) || wr_open;
  assign push    = wr_open && dev_ack;
  assign pop     = drain_phase && !fifo_empty && mem_gnt;
  assign timeout = offer && !dev_ack && (to_cnt == 4'd15);

  assign dma_ack      = (state == GRANT) || offer;
  assign dma_end_flag = (state == DONE);
  assign busy         = (state != IDLE);
  assign mem_we       = drain_phase && !fifo_empty;
  assign mem_req      = (state == RD_FETCH) || mem_we;
  assign mem_addr     = addr;
  assign mem_wdata    = mem_we ? fifo_mem[rd_ptr] : '0;

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (rqst) state_next = (num_words == '0) ? DONE : GRANT;
      end
      GRANT:    state_next = dir_q ? RD_FETCH : WR_XFER;
      RD_FETCH: if (mem_gnt) state_next = RD_WAIT;
      RD_WAIT:  state_next = RD_OFFER;
      RD_OFFER: begin
        if (timeout)      state_next = ERR;
        else if (dev_ack) state_next = (cnt_inc == len_q) ? DONE : RD_FETCH;
      end
      WR_XFER: begin
        if (timeout)                          state_next = ERR;
        else if (push && (cnt_inc == len_q))  state_next = WR_DRAIN;
      end
      WR_DRAIN: if (fifo_empty) state_next = DONE;
      DONE:     state_next = IDLE;
      ERR:      state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      len_q    <= '0;
      dir_q    <= 1'b0;
      cnt      <= '0;
      addr     <= '0;
      to_cnt   <= '0;
      dev_in   <= '0;
      error    <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      state <= state_next;

      if ((state == IDLE) && rqst) begin
        len_q  <= num_words;
        dir_q  <= rd_wr;
        addr   <= start_address;
        cnt    <= '0;
        error  <= 1'b0;
      end

      if (state == RD_WAIT) dev_in <= mem_rdata;

      if ((state == RD_OFFER) && dev_ack && !timeout) begin
        cnt  <= cnt_inc;
        addr <= addr + ADDR_ONE;
      end
      if (push) cnt  <= cnt_inc;
      if (pop)  addr <= addr + ADDR_ONE;

      // Counts consecutive offered-but-unanswered cycles; any other cycle restarts it.
      if (offer && !dev_ack) to_cnt <= to_cnt + 4'd1;
      else                   to_cnt <= '0;

      if (timeout) error <= 1'b1;

      if (state == ERR) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        fifo_cnt <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 2'd1;
        if (pop)  rd_ptr <= rd_ptr + 2'd1;
        if (push && !pop)      fifo_cnt <= fifo_cnt + 3'd1;
        else if (pop && !push) fifo_cnt <= fifo_cnt - 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= dev_out;
  end

endmodule

// File: tb/tb_dma_channel.sv
// Bench for dma_channel: a transaction-level model of memory, device and FIFO
// occupancy predicts every handshake, memory access and end/error event.
module tb_dma_channel;

  localparam int DATA     = 8;
  localparam int ADD      = 7;
  localparam int WORD     = 5;
  localparam int MEM_SIZE = 1 << ADD;
  localparam int BUDGET   = 600;

  logic            clk = 1'b0;
  logic            reset;
  logic            rqst;
  logic [WORD:0]   num_words;
  logic [ADD-1:0]  start_address;
  logic            rd_wr;
  logic            dev_ack;
  logic [DATA-1:0] dev_out;
  logic            dma_ack;
  logic [DATA-1:0] dev_in;
  logic            dma_end_flag;
  logic            mem_req;
  logic            mem_gnt;
  logic            mem_we;
  logic [ADD-1:0]  mem_addr;
  logic [DATA-1:0] mem_wdata;
  logic [DATA-1:0] mem_rdata;
  logic            busy;
  logic            error;

  always #5 clk = ~clk;

  dma_channel #(.DATA(DATA), .ADD(ADD), .WORD(WORD)) dut (
    .clk(clk), .reset(reset), .rqst(rqst), .num_words(num_words),
    .start_address(start_address), .rd_wr(rd_wr), .dev_ack(dev_ack),
    .dev_out(dev_out), .dma_ack(dma_ack), .dev_in(dev_in),
    .dma_end_flag(dma_end_flag), .mem_req(mem_req), .mem_gnt(mem_gnt),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .error(error)
  );

  int checks = 0;
  int errors = 0;
  logic [DATA-1:0] mem [MEM_SIZE];

  typedef struct {
    int nw;
    int sa;
    bit rw;
    int ack_mode;   // 0 always, 1 random, 2 never, 3 three idle cycles per word
    int gnt_mode;   // 0 always, 1 random, 2 held low for the first 10 cycles
    bit alt;        // write data 0x0A, 0xF5, ...
    int exp_flags;
    bit exp_err;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic run_xfer(input int nw, input int sa, input bit rw, input int ack_mode,
                          input int gnt_mode, input bit alt,
                          output int flags, output bit err_seen, output int flag_cyc);
    logic [DATA-1:0] exp_q[$];
    logic [DATA-1:0] words[$];
    logic [ADD-1:0]  pend_addr;
    int acc, wr, run0, wait_left, occ, cyc;
    bit grant_cyc, pend, timed_out, finished, exp_ack, offered, accepted;
    acc = 0; wr = 0; run0 = 0; wait_left = 3; occ = 0;
    pend = 0; timed_out = 0; finished = 0; pend_addr = '0;
    flags = 0; flag_cyc = -1;
    for (int i = 0; i < nw; i++) begin
      if (rw) exp_q.push_back(mem[(sa + i) % MEM_SIZE]);
      else    words.push_back(alt ? (((i % 2) != 0) ? 8'hF5 : 8'h0A) : DATA'($urandom));
    end

    rqst = 1'b1; num_words = nw[WORD:0]; start_address = sa[ADD-1:0]; rd_wr = rw;
    dev_ack = 1'($urandom_range(0, 1)); mem_gnt = 1'b0;
    step();
    grant_cyc = (nw != 0);

    for (cyc = 0; cyc < BUDGET && !finished; cyc++) begin
      mem_rdata = pend ? mem[pend_addr] : DATA'($urandom);
      pend = 0;
      if (cyc == 0) check("error_clear_on_rqst", error, 0);
      if (!busy) begin
        finished = 1;
      end else if (timed_out) begin
        check("err_flag", error, 1);
        check("err_no_end", dma_end_flag, 0);
        check("err_no_mem_req", mem_req, 0);
        check("err_no_ack", dma_ack, 0);
        dev_ack = 1'($urandom_range(0, 1));
        mem_gnt = 1'($urandom_range(0, 1));
      end else begin
        case (ack_mode)
          0:       dev_ack = 1'b1;
          1:       dev_ack = 1'($urandom_range(0, 1));
          2:       dev_ack = 1'b0;
          default: dev_ack = (wait_left == 0);
        endcase
        case (gnt_mode)
          0:       mem_gnt = 1'b1;
          1:       mem_gnt = 1'($urandom_range(0, 1));
          default: mem_gnt = (cyc >= 10);
        endcase
        if (grant_cyc) begin
          check("grant_ack", dma_ack, 1);
          check("grant_no_req", mem_req, 0);
        end
        if (dma_end_flag) begin
          flags++;
          if (flag_cyc < 0) flag_cyc = cyc;
          check("end_after_all_words", rw ? acc : wr, nw);
          check("end_no_ack", dma_ack, 0);
          check("end_no_req", mem_req, 0);
        end
        if (rw) begin
          offered = dma_ack && !grant_cyc;
          accepted = offered && dev_ack;
          if (offered) begin
            if (exp_q.size() == 0) check("rd_spurious_ack", dma_ack, 0);
            else check("rd_dev_in", dev_in, exp_q[0]);
          end
          if (mem_req) begin
            check("rd_we", mem_we, 0);
            check("rd_addr", mem_addr, (sa + acc) % MEM_SIZE);
            if (mem_gnt) begin
              pend = 1;
              pend_addr = ADD'((sa + acc) % MEM_SIZE);
            end
          end
          if (accepted && exp_q.size() != 0) begin
            void'(exp_q.pop_front());
            acc++;
          end
        end else begin
          occ = acc - wr;
          exp_ack = !grant_cyc && (occ < 4) && (acc < nw);
          offered = exp_ack;
          accepted = exp_ack && dev_ack;
          if (!grant_cyc) check("wr_ack", dma_ack, exp_ack);
          check("wr_req", mem_req, occ > 0);
          if (mem_req && occ > 0) begin
            check("wr_we", mem_we, 1);
            check("wr_addr", mem_addr, (sa + wr) % MEM_SIZE);
            check("wr_data", mem_wdata, words[wr]);
          end
          if (occ > 0 && mem_gnt) begin
            mem[(sa + wr) % MEM_SIZE] = words[wr];
            wr++;
          end
          dev_out = (acc < nw) ? words[acc] : DATA'($urandom);
          if (accepted) acc++;
        end
        if (ack_mode == 3 && offered) wait_left = accepted ? 3 : wait_left - 1;
        if (offered && !dev_ack) run0++;
        else run0 = 0;
        if (run0 == 16) timed_out = 1;
        grant_cyc = 0;
      end
      if (!finished) begin
        rqst = 1'($urandom_range(0, 1));
        num_words = (WORD+1)'($urandom);
        start_address = ADD'($urandom);
        rd_wr = 1'($urandom_range(0, 1));
        step();
      end
    end

    rqst = 1'b0; dev_ack = 1'b0; mem_gnt = 1'b0;
    check("xfer_idle_within_budget", busy, 0);
    check("xfer_end_pulses", flags, timed_out ? 0 : 1);
    check("xfer_error_sticky", error, timed_out);
    check("idle_no_ack", dma_ack, 0);
    check("idle_no_req", mem_req, 0);
    if (!timed_out) check("xfer_word_count", rw ? acc : wr, nw);
    err_seen = error;
  endtask

  initial begin
    vec_t vecs[10];
    int flags, fc, nw, sa;
    bit es;

    reset = 1'b0; rqst = 1'b1; num_words = 6'd3; start_address = '0; rd_wr = 1'b1;
    dev_ack = 1'b1; dev_out = '0; mem_gnt = 1'b1; mem_rdata = '0;
    for (int i = 0; i < MEM_SIZE; i++) mem[i] = DATA'($urandom);
    mem['h10] = 8'hA1; mem['h11] = 8'hA2; mem['h12] = 8'hA3;

    repeat (3) step();
    check("rst_dma_ack", dma_ack, 0);
    check("rst_end_flag", dma_end_flag, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_busy", busy, 0);
    check("rst_error", error, 0);
    check("rst_dev_in", dev_in, 0);
    check("rst_mem_addr", mem_addr, 0);
    reset = 1'b1; rqst = 1'b0; dev_ack = 1'b0; mem_gnt = 1'b0;
    step();
    check("post_rst_busy", busy, 0);

    vecs[0] = '{3, 'h10, 1'b1, 0, 0, 1'b0, 1, 1'b0};
    vecs[1] = '{6, 'h7E, 1'b0, 0, 2, 1'b1, 1, 1'b0};
    vecs[2] = '{0, 'h20, 1'b0, 0, 0, 1'b0, 1, 1'b0};
    vecs[3] = '{0, 'h21, 1'b1, 0, 0, 1'b0, 1, 1'b0};
    vecs[4] = '{2, 'h30, 1'b1, 2, 0, 1'b0, 0, 1'b1};
    vecs[5] = '{4, 'h40, 1'b1, 3, 1, 1'b0, 1, 1'b0};
    vecs[6] = '{5, 'h50, 1'b0, 2, 0, 1'b0, 0, 1'b1};
    vecs[7] = '{8, 'h7C, 1'b1, 1, 1, 1'b0, 1, 1'b0};
    vecs[8] = '{9, 'h05, 1'b0, 3, 1, 1'b0, 1, 1'b0};
    vecs[9] = '{1, 'h7F, 1'b0, 0, 0, 1'b0, 1, 1'b0};

    for (int v = 0; v < 10; v++) begin
      run_xfer(vecs[v].nw, vecs[v].sa, vecs[v].rw, vecs[v].ack_mode,
               vecs[v].gnt_mode, vecs[v].alt, flags, es, fc);
      check($sformatf("vec%0d_flags", v), flags, vecs[v].exp_flags);
      check($sformatf("vec%0d_error", v), es, vecs[v].exp_err);
      if (vecs[v].nw == 0) check($sformatf("vec%0d_zero_len_timing", v), fc, 0);
    end

    // Reset with two words parked in the FIFO and memory stalled.
    rqst = 1'b1; num_words = 6'd6; start_address = 7'h60; rd_wr = 1'b0;
    dev_ack = 1'b1; mem_gnt = 1'b0; dev_out = 8'h3C;
    step();
    rqst = 1'b0;
    check("mr_grant_ack", dma_ack, 1);
    step();
    check("mr_accept1", dma_ack, 1);
    step();
    check("mr_accept2", dma_ack, 1);
    step();
    check("mr_fifo_req", mem_req, 1);
    reset = 1'b0; dev_ack = 1'b0;
    step();
    mem_gnt = 1'b1;
    check("mr_busy", busy, 0);
    check("mr_dma_ack", dma_ack, 0);
    check("mr_end_flag", dma_end_flag, 0);
    check("mr_mem_req", mem_req, 0);
    check("mr_mem_we", mem_we, 0);
    check("mr_error", error, 0);
    check("mr_dev_in", dev_in, 0);
    check("mr_mem_addr", mem_addr, 0);
    reset = 1'b1;
    step();
    check("mr_idle_after", busy, 0);
    check("mr_no_req_after", mem_req, 0);
    mem_gnt = 1'b0;
    run_xfer(4, 'h60, 1'b0, 0, 1, 1'b0, flags, es, fc);
    check("mr_fresh_flags", flags, 1);
    run_xfer(3, 'h60, 1'b1, 1, 1, 1'b0, flags, es, fc);
    check("mr_readback_flags", flags, 1);

    for (int r = 0; r < 25; r++) begin
      nw = $urandom_range(0, 12);
      sa = $urandom_range(0, MEM_SIZE - 1);
      run_xfer(nw, sa, 1'($urandom_range(0, 1)), $urandom_range(0, 1) * 3 + $urandom_range(0, 1) % 1,
               $urandom_range(0, 1), 1'b0, flags, es, fc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
